// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and external-stall handling.
// Optional performance counters are built only when IDEX_PERF_CNT_EN is defined.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall_ext,
  input  logic             i_flush,
  input  logic             i_valid_ID,
  input  logic [XLEN-1:0]  i_pc_ID,
  input  logic [4:0]       i_rs1_addr_ID,
  input  logic [4:0]       i_rs2_addr_ID,
  input  logic [4:0]       i_rd_addr_ID,
  input  logic             i_uses_rs1_ID,
  input  logic             i_uses_rs2_ID,
  input  logic [XLEN-1:0]  i_rs1_val_ID,
  input  logic [XLEN-1:0]  i_rs2_val_ID,
  input  logic [XLEN-1:0]  i_imm_ID,
  input  logic [2:0]       i_funct3_ID,
  input  logic             i_funct7b5_ID,
  input  logic [8:0]       i_ctrl_ID,
  output logic             o_valid_IDEX,
  output logic [XLEN-1:0]  o_pc_IDEX,
  output logic [4:0]       o_rs1_addr_IDEX,
  output logic [4:0]       o_rs2_addr_IDEX,
  output logic [4:0]       o_rd_addr_IDEX,
  output logic             o_uses_rs1_IDEX,
  output logic             o_uses_rs2_IDEX,
  output logic [XLEN-1:0]  o_rs1_val_IDEX,
  output logic [XLEN-1:0]  o_rs2_val_IDEX,
  output logic [XLEN-1:0]  o_imm_IDEX,
  output logic [2:0]       o_funct3_IDEX,
  output logic             o_funct7b5_IDEX,
  output logic [8:0]       o_ctrl_IDEX,
  output logic             o_bubble_IDEX,
  output logic             o_stall_IFID,
  output logic [CNT_W-1:0] o_lu_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // ctrl layout: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump, ALUOp[1:0]}
  localparam int unsigned MemReadBit = 7;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [8:0]      ctrl;
  } idex_t;

  idex_t idex_q, idex_d;
  logic  bubble_q;
  logic  rs1_hit, rs2_hit, lu;
  logic  load_bubble, load_instr;

  // Store data on rs2 is included: no MEM-to-MEM path is assumed downstream.
  always_comb begin
    rs1_hit = i_uses_rs1_ID & (idex_q.rd_addr == i_rs1_addr_ID);
    rs2_hit = i_uses_rs2_ID & (idex_q.rd_addr == i_rs2_addr_ID);
    lu      = idex_q.valid & idex_q.ctrl[MemReadBit] & (idex_q.rd_addr != 5'd0) &
              i_valid_ID & (rs1_hit | rs2_hit);
  end

  assign o_stall_IFID = (lu | i_stall_ext) & ~i_flush;
  assign load_bubble  = i_flush | (~i_stall_ext & lu);
  assign load_instr   = ~i_flush & ~i_stall_ext & ~lu;

  always_comb begin
    idex_d = '{
      valid:    i_valid_ID,
      pc:       i_pc_ID,
      rs1_addr: i_rs1_addr_ID,
      rs2_addr: i_rs2_addr_ID,
      rd_addr:  i_rd_addr_ID,
      uses_rs1: i_uses_rs1_ID,
      uses_rs2: i_uses_rs2_ID,
      rs1_val:  i_rs1_val_ID,
      rs2_val:  i_rs2_val_ID,
      imm:      i_imm_ID,
      funct3:   i_funct3_ID,
      funct7b5: i_funct7b5_ID,
      ctrl:     i_ctrl_ID
    };
  end

  // Bubbles clear the whole entry so RegWrite/MemWrite are guaranteed low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idex_q   <= '0;
      bubble_q <= 1'b0;
    end else if (load_bubble) begin
      idex_q   <= '0;
      bubble_q <= 1'b1;
    end else if (load_instr) begin
      idex_q   <= idex_d;
      bubble_q <= ~i_valid_ID;
    end
  end

  assign o_valid_IDEX    = idex_q.valid;
  assign o_pc_IDEX       = idex_q.pc;
  assign o_rs1_addr_IDEX = idex_q.rs1_addr;
  assign o_rs2_addr_IDEX = idex_q.rs2_addr;
  assign o_rd_addr_IDEX  = idex_q.rd_addr;
  assign o_uses_rs1_IDEX = idex_q.uses_rs1;
  assign o_uses_rs2_IDEX = idex_q.uses_rs2;
  assign o_rs1_val_IDEX  = idex_q.rs1_val;
  assign o_rs2_val_IDEX  = idex_q.rs2_val;
  assign o_imm_IDEX      = idex_q.imm;
  assign o_funct3_IDEX   = idex_q.funct3;
  assign o_funct7b5_IDEX = idex_q.funct7b5;
  assign o_ctrl_IDEX     = idex_q.ctrl;
  assign o_bubble_IDEX   = bubble_q;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q;
  logic             lu_taken;

  assign lu_taken = ~i_flush & ~i_stall_ext & lu;

  // Saturating counters: stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_taken && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      if (i_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign o_lu_stall_cnt = lu_cnt_q;
  assign o_flush_cnt    = flush_cnt_q;
`else
  assign o_lu_stall_cnt = '0;
  assign o_flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset/saturation sequences and
// randomized traffic against a priority-rule reference model.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CntW = 4;
  localparam int          Sat  = (1 << CntW) - 1;
`ifdef IDEX_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam logic [8:0] CAddi = 9'b100010010;
  localparam logic [8:0] CLw   = 9'b110110000;
  localparam logic [8:0] CR    = 9'b100000010;
  localparam logic [8:0] CSw   = 9'b001010000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f7;
    logic [8:0]  ctrl;
  } instr_t;

  typedef struct {
    instr_t     ins;
    bit         fl;
    bit         sx;
    bit         e_stall;
    bit         e_valid;
    bit         e_bubble;
    logic [4:0] e_rd;
    logic [8:0] e_ctrl;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_stall_ext, i_flush, i_valid_ID;
  logic [XLEN-1:0]  i_pc_ID, i_rs1_val_ID, i_rs2_val_ID, i_imm_ID;
  logic [4:0]       i_rs1_addr_ID, i_rs2_addr_ID, i_rd_addr_ID;
  logic             i_uses_rs1_ID, i_uses_rs2_ID, i_funct7b5_ID;
  logic [2:0]       i_funct3_ID;
  logic [8:0]       i_ctrl_ID;
  logic             o_valid_IDEX, o_uses_rs1_IDEX, o_uses_rs2_IDEX, o_funct7b5_IDEX;
  logic [XLEN-1:0]  o_pc_IDEX, o_rs1_val_IDEX, o_rs2_val_IDEX, o_imm_IDEX;
  logic [4:0]       o_rs1_addr_IDEX, o_rs2_addr_IDEX, o_rd_addr_IDEX;
  logic [2:0]       o_funct3_IDEX;
  logic [8:0]       o_ctrl_IDEX;
  logic             o_bubble_IDEX, o_stall_IFID;
  logic [CntW-1:0]  o_lu_stall_cnt, o_flush_cnt;

  always #5 i_clk = ~i_clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CntW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall_ext(i_stall_ext), .i_flush(i_flush),
    .i_valid_ID(i_valid_ID), .i_pc_ID(i_pc_ID), .i_rs1_addr_ID(i_rs1_addr_ID),
    .i_rs2_addr_ID(i_rs2_addr_ID), .i_rd_addr_ID(i_rd_addr_ID),
    .i_uses_rs1_ID(i_uses_rs1_ID), .i_uses_rs2_ID(i_uses_rs2_ID),
    .i_rs1_val_ID(i_rs1_val_ID), .i_rs2_val_ID(i_rs2_val_ID), .i_imm_ID(i_imm_ID),
    .i_funct3_ID(i_funct3_ID), .i_funct7b5_ID(i_funct7b5_ID), .i_ctrl_ID(i_ctrl_ID),
    .o_valid_IDEX(o_valid_IDEX), .o_pc_IDEX(o_pc_IDEX), .o_rs1_addr_IDEX(o_rs1_addr_IDEX),
    .o_rs2_addr_IDEX(o_rs2_addr_IDEX), .o_rd_addr_IDEX(o_rd_addr_IDEX),
    .o_uses_rs1_IDEX(o_uses_rs1_IDEX), .o_uses_rs2_IDEX(o_uses_rs2_IDEX),
    .o_rs1_val_IDEX(o_rs1_val_IDEX), .o_rs2_val_IDEX(o_rs2_val_IDEX),
    .o_imm_IDEX(o_imm_IDEX), .o_funct3_IDEX(o_funct3_IDEX),
    .o_funct7b5_IDEX(o_funct7b5_IDEX), .o_ctrl_IDEX(o_ctrl_IDEX),
    .o_bubble_IDEX(o_bubble_IDEX), .o_stall_IFID(o_stall_IFID),
    .o_lu_stall_cnt(o_lu_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what EX should hold, plus event tallies.
  instr_t m_e;
  bit     m_bub;
  int     m_lu_n, m_fl_n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                                input bit u1, input logic [4:0] rs2, input bit u2,
                                input logic [4:0] rd, input logic [31:0] imm,
                                input logic [8:0] c);
    instr_t r;
    r = '{valid: v, pc: pc, rs1: rs1, rs2: rs2, rd: rd, u1: u1, u2: u2,
          v1: 32'hA000_0000 | {27'd0, rs1}, v2: 32'hB000_0000 | {27'd0, rs2},
          imm: imm, f3: 3'd2, f7: 1'b0, ctrl: c};
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid = ($urandom_range(0, 99) < 85);
    r.pc    = $urandom;
    r.rs1   = 5'($urandom_range(0, 7));
    r.rs2   = 5'($urandom_range(0, 7));
    r.rd    = 5'($urandom_range(0, 7));
    r.u1    = 1'($urandom_range(0, 1));
    r.u2    = 1'($urandom_range(0, 1));
    r.v1    = $urandom;
    r.v2    = $urandom;
    r.imm   = $urandom;
    r.f3    = 3'($urandom_range(0, 7));
    r.f7    = 1'($urandom_range(0, 1));
    r.ctrl  = 9'($urandom_range(0, 511));
    r.ctrl[7] = ($urandom_range(0, 9) < 4);
    return r;
  endfunction

  function automatic bit model_lu(input instr_t ins);
    bool_dep: begin end
    return m_e.valid && m_e.ctrl[7] && (m_e.rd != 5'd0) && ins.valid &&
           ((ins.u1 && ins.rs1 == m_e.rd) || (ins.u2 && ins.rs2 == m_e.rd));
  endfunction

  function automatic int sat(input int n);
    return (n > Sat) ? Sat : n;
  endfunction

  task automatic model_reset();
    m_e = '0; m_bub = 1'b0; m_lu_n = 0; m_fl_n = 0;
  endtask

  task automatic model_edge(input instr_t ins, input bit fl, input bit sx);
    if (fl) begin
      m_e = '0; m_bub = 1'b1; m_fl_n++;
    end else if (sx) begin
      // hold
    end else if (model_lu(ins)) begin
      m_e = '0; m_bub = 1'b1; m_lu_n++;
    end else begin
      m_e = ins; m_bub = ~ins.valid;
    end
  endtask

  task automatic drive(input instr_t ins, input bit fl, input bit sx);
    i_valid_ID = ins.valid;  i_pc_ID = ins.pc;
    i_rs1_addr_ID = ins.rs1; i_rs2_addr_ID = ins.rs2; i_rd_addr_ID = ins.rd;
    i_uses_rs1_ID = ins.u1;  i_uses_rs2_ID = ins.u2;
    i_rs1_val_ID = ins.v1;   i_rs2_val_ID = ins.v2;  i_imm_ID = ins.imm;
    i_funct3_ID = ins.f3;    i_funct7b5_ID = ins.f7; i_ctrl_ID = ins.ctrl;
    i_flush = fl;            i_stall_ext = sx;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, o_valid_IDEX, m_e.valid);
    chk({tag, "_bubble"}, o_bubble_IDEX, m_bub);
    chk({tag, "_rd"}, o_rd_addr_IDEX, m_e.rd);
    chk({tag, "_ctrl"}, o_ctrl_IDEX, m_e.ctrl);
    if (m_e.valid) begin
      chk({tag, "_pc"}, o_pc_IDEX, m_e.pc);
      chk({tag, "_rs"}, {o_rs1_addr_IDEX, o_rs2_addr_IDEX, o_uses_rs1_IDEX, o_uses_rs2_IDEX},
          {m_e.rs1, m_e.rs2, m_e.u1, m_e.u2});
      chk({tag, "_vals"}, {o_rs1_val_IDEX, o_rs2_val_IDEX}, {m_e.v1, m_e.v2});
      chk({tag, "_imm"}, {o_imm_IDEX, o_funct3_IDEX, o_funct7b5_IDEX},
          {m_e.imm, m_e.f3, m_e.f7});
    end
    chk({tag, "_lucnt"}, o_lu_stall_cnt, PerfEn ? sat(m_lu_n) : 0);
    chk({tag, "_flcnt"}, o_flush_cnt, PerfEn ? sat(m_fl_n) : 0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled before/after the edge.
  task automatic step(input instr_t ins, input bit fl, input bit sx, input string tag);
    drive(ins, fl, sx);
    #2;
    chk({tag, "_stall"}, o_stall_IFID, (model_lu(ins) | sx) & ~fl);
    @(posedge i_clk);
    model_edge(ins, fl, sx);
    #1;
    check_model(tag);
  endtask

  vec_t   vecs[$];
  instr_t i_addi, i_lw5, i_add, i_lw0, i_add00, i_addi8, i_sw, i_nop;

  task automatic add_vec(input instr_t ins, input bit fl, input bit sx, input bit st,
                         input bit v, input bit b, input logic [4:0] rd, input logic [8:0] c);
    vec_t t;
    t = '{ins: ins, fl: fl, sx: sx, e_stall: st, e_valid: v, e_bubble: b, e_rd: rd, e_ctrl: c};
    vecs.push_back(t);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'd0);
    drive(i_nop, 1'b0, 1'b0);
    model_reset();
    #3;
    chk("rst_stall", o_stall_IFID, 0);
    check_model("rst");
    #9 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    i_addi  = mk(1, 32'h100, 0, 1, 5, 0, 1, 32'd5, CAddi);
    i_lw5   = mk(1, 32'h104, 1, 1, 0, 0, 5, 32'd0, CLw);
    i_add   = mk(1, 32'h108, 5, 1, 7, 1, 6, 32'd0, CR);
    i_lw0   = mk(1, 32'h10C, 2, 1, 0, 0, 0, 32'd0, CLw);
    i_add00 = mk(1, 32'h110, 0, 1, 0, 1, 6, 32'd0, CR);
    i_addi8 = mk(1, 32'h114, 8, 1, 5, 0, 6, 32'd1, CAddi);
    i_sw    = mk(1, 32'h118, 9, 1, 5, 1, 0, 32'd0, CSw);

    //       instr    fl sx stall valid bub rd  ctrl
    add_vec(i_addi,  0, 0, 0, 1, 0, 1, CAddi);
    add_vec(i_lw5,   0, 0, 0, 1, 0, 5, CLw);
    add_vec(i_add,   0, 0, 1, 0, 1, 0, 9'd0);
    add_vec(i_add,   0, 0, 0, 1, 0, 6, CR);
    add_vec(i_lw0,   0, 0, 0, 1, 0, 0, CLw);
    add_vec(i_add00, 0, 0, 0, 1, 0, 6, CR);
    add_vec(i_lw5,   0, 0, 0, 1, 0, 5, CLw);
    add_vec(i_addi8, 0, 0, 0, 1, 0, 6, CAddi);
    add_vec(i_lw5,   0, 0, 0, 1, 0, 5, CLw);
    add_vec(i_sw,    0, 0, 1, 0, 1, 0, 9'd0);
    add_vec(i_sw,    0, 0, 0, 1, 0, 0, CSw);
    add_vec(i_lw5,   0, 0, 0, 1, 0, 5, CLw);
    add_vec(i_add,   1, 1, 0, 0, 1, 0, 9'd0);
    add_vec(i_lw5,   0, 0, 0, 1, 0, 5, CLw);
    add_vec(i_add,   0, 1, 1, 1, 0, 5, CLw);
    add_vec(i_add,   0, 1, 1, 1, 0, 5, CLw);
    add_vec(i_add,   0, 0, 1, 0, 1, 0, 9'd0);
    add_vec(i_add,   0, 0, 0, 1, 0, 6, CR);
    add_vec(i_nop,   0, 0, 0, 0, 1, 0, 9'd0);
    add_vec(i_addi,  1, 0, 0, 0, 1, 0, 9'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].fl, vecs[i].sx);
      #2;
      chk($sformatf("tbl%0d_stall", i), o_stall_IFID, vecs[i].e_stall);
      @(posedge i_clk);
      model_edge(vecs[i].ins, vecs[i].fl, vecs[i].sx);
      #1;
      chk($sformatf("tbl%0d_valid", i), o_valid_IDEX, vecs[i].e_valid);
      chk($sformatf("tbl%0d_bubble", i), o_bubble_IDEX, vecs[i].e_bubble);
      chk($sformatf("tbl%0d_rd", i), o_rd_addr_IDEX, vecs[i].e_rd);
      chk($sformatf("tbl%0d_ctrl", i), o_ctrl_IDEX, vecs[i].e_ctrl);
      check_model($sformatf("tbl%0d", i));
    end
    chk("tbl_lucnt", o_lu_stall_cnt, PerfEn ? 3 : 0);
    chk("tbl_flcnt", o_flush_cnt, PerfEn ? 2 : 0);

    // Asynchronous reset in the middle of a pending load-use stall.
    step(i_lw5, 0, 0, "mr_lw");
    drive(i_add, 0, 0);
    #2;
    chk("mr_pre_stall", o_stall_IFID, 1);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr_stall", o_stall_IFID, 0);
    chk("mr_outs", {o_valid_IDEX, o_bubble_IDEX, o_rd_addr_IDEX, o_ctrl_IDEX, o_imm_IDEX}, 0);
    chk("mr_vals", {o_pc_IDEX, o_rs1_val_IDEX}, 0);
    chk("mr_cnts", {o_lu_stall_cnt, o_flush_cnt}, 0);
    #2 i_rst_n = 1'b1;
    #2;
    chk("mr_post_stall", o_stall_IFID, 0);
    @(posedge i_clk);
    model_edge(i_add, 0, 0);
    #1;
    check_model("mr_post");

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      instr_t r;
      bit fl, sx;
      r  = rand_instr();
      fl = ($urandom_range(0, 99) < 8);
      sx = ($urandom_range(0, 99) < 15);
      step(r, fl, sx, $sformatf("rnd%0d", k));
    end

    // Counter saturation after a clean reset: 17 load-use events on a 4-bit counter.
    @(negedge i_clk);
    i_rst_n = 1'b0;
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 17; k++) begin
      step(i_lw5, 0, 0, $sformatf("sat%0d_lw", k));
      step(i_add, 0, 0, $sformatf("sat%0d_bub", k));
      step(i_add, 0, 0, $sformatf("sat%0d_add", k));
    end
    chk("sat_lucnt", o_lu_stall_cnt, PerfEn ? 15 : 0);
    chk("sat_flcnt", o_flush_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
